morse_encoder: RTL and testbench
================================

Name: morse_encoder

Overview:
Upstream stage of morse_tx. Accepts ASCII characters over a valid/ready handshake and serialises each one into a timed stream of 2-bit dit/dah symbols on ditDah_out, which connects directly to morse_tx ditDah_in. Symbol coding on the 2-bit bus:
- dit = 2'b00
- dah = 2'b11
- gap = 2'b01 (inter-element, letter and word spacing)
- 2'b10 is never driven.

Parameters:
SYM_CYCLES, 2, clocks each dit/dah symbol is held; also the length of the inter-element gap; legal range 1..255
GAP_CYCLES, 3, clocks of gap after the last symbol of a letter; legal range 1..255
WORD_CYCLES, 7, clocks of gap for a space character; legal range 1..255

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
char_in  input  8  ASCII character
char_valid  input  1  char_in is valid
char_ready  output  1  encoder can accept a character this cycle
ditDah_out  output  [0:1]  symbol to morse_tx
sym_valid  output  1  one-cycle pulse on the first cycle of each dit/dah
busy  output  1  encoder is not in IDLE
err_char  output  1  one-cycle pulse when an unsupported character is accepted

Behaviour:
Reset (asynchronous, rst=1):
- state=IDLE, ditDah_out=2'b01, sym_valid=0, err_char=0, busy=0, char_ready=1.
- All counters and the code register are cleared.
- Reset asserted mid-character aborts the character immediately. No further symbols are emitted.

Handshake:
- A transfer occurs when char_valid & char_ready are both 1 at a rising edge.
- char_ready = (state==IDLE). It is a registered-state decode, with no combinational path from char_valid.
- While char_ready=0, char_in and char_valid are ignored. Nothing is queued.

Character decode (at accept):
- 'A'-'Z' (0x41-0x5A) and 'a'-'z' (0x61-0x7A, folded to uppercase) use the standard International Morse table.
- The table is stored as a code (MSB = first element, 1 = dah) plus a length of 1..4.
- Space (0x20) emits no symbols and goes to WGAP.
- Any other character pulses err_char for 1 cycle (the cycle after accept), emits nothing and stays in IDLE.

FSM states: IDLE, EMIT, EGAP, LGAP, WGAP.
- IDLE:
  - Letter accepted -> EMIT, element index=0, cycle counter=0.
  - Space accepted -> WGAP.
- EMIT:
  - ditDah_out = 2'b11 if the current element is dah, else 2'b00.
  - sym_valid=1 only on counter==0.
  - After SYM_CYCLES clocks: go to EGAP if more elements remain, else go to LGAP.
- EGAP: ditDah_out=01 for SYM_CYCLES clocks, then index+1 and -> EMIT.
- LGAP: ditDah_out=01 for GAP_CYCLES clocks, then -> IDLE.
- WGAP: ditDah_out=01 for WORD_CYCLES clocks, then -> IDLE.
- In IDLE, ditDah_out=01.

Latency and throughput:
- The first symbol appears on the first rising edge after the accepting edge (1-cycle latency).
- A letter of n elements occupies n·SYM_CYCLES + (n-1)·SYM_CYCLES + GAP_CYCLES clocks, then IDLE for ≥1 cycle before the next accept.

Outputs:
- busy = (state != IDLE).
- All outputs are registered.

Boundary conditions:
- When a counter reaches its parameter-1 in the same cycle char_valid is asserted, the character is not accepted. It is accepted in the following IDLE cycle.
- Counters are 8 bits and never wrap within a legal parameter range.

Optional Feature:
MORSE_DIGITS_EN
- Defined:
  - '0'-'9' (0x30-0x39) are encoded with 5-element standard codes, so the table length field supports 5.
  - Digits do not pulse err_char.
- Undefined:
  - Digits are treated as unsupported: err_char pulses and no symbols are emitted.
  - The table holds letters only, with a maximum length of 4.

Test Plan:
1. Defaults; accept 'E' (0x45).
   - ditDah_out = 00 for 2 clocks, with sym_valid=1 on the first only.
   - Then 01 for 3 clocks.
   - char_ready=1 on the 6th clock after accept. busy=1 for exactly 5 clocks.
2. Accept 'a' (0x61).
   - Sequence: 00,00,01,01,11,11,01,01,01.
   - Exactly 2 sym_valid pulses, identical to 'A'.
3. Accept 0x20.
   - No sym_valid, ditDah_out=01 for 7 clocks, busy=1 for 7 clocks.
   - Then accept 'T' -> 11,11,01,01,01.
4. Accept '#' (0x23).
   - err_char=1 for exactly 1 clock, no sym_valid, char_ready stays 1.
   - '5' behaves the same without MORSE_DIGITS_EN.
   - With MORSE_DIGITS_EN, '5' produces 5 dits.
5. Hold char_valid=1 with 'Q' then 'Z' during busy.
   - 'Q' yields dah,dah,dit,dah.
   - 'Z' is accepted only after LGAP ends, and yields dah,dah,dit,dit.
   - No character is dropped or duplicated.
6. Assert rst during the second element of 'Q'.
   - Outputs go to their reset values asynchronously (ditDah_out=01, busy=0, char_ready=1), with no further sym_valid.
   - After release, accepting 'E' behaves as in scenario 1.

Source files
------------

// File: rtl/morse_encoder.sv
`default_nettype none
// ============================================================================
// Module      : morse_encoder
// Description : Serialises accepted ASCII characters into timed 2-bit
//               dit/dah/gap symbols for morse_tx. Define MORSE_DIGITS_EN to
//               add the 5-element digit codes '0'-'9'.
// Revision    : 1.0 - initial release
// ============================================================================
module morse_encoder #(
  parameter int SYM_CYCLES  = 2,
  parameter int GAP_CYCLES  = 3,
  parameter int WORD_CYCLES = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       char_ready,
  output logic [0:1] ditDah_out,
  output logic       sym_valid,
  output logic       busy,
  output logic       err_char
);

`ifdef MORSE_DIGITS_EN
  localparam int c_CW = 5;
`else
  localparam int c_CW = 4;
`endif

  localparam logic [7:0] c_SYM_LAST  = 8'(SYM_CYCLES - 1);
  localparam logic [7:0] c_GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] c_WORD_LAST = 8'(WORD_CYCLES - 1);

  localparam logic [1:0] c_DIT = 2'b00;
  localparam logic [1:0] c_DAH = 2'b11;
  localparam logic [1:0] c_GAP = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EMIT = 3'd1,
    S_EGAP = 3'd2,
    S_LGAP = 3'd3,
    S_WGAP = 3'd4
  } state_t;

  state_t            r_state;
  logic [7:0]        r_cnt;
  logic [c_CW-1:0]   r_code;
  logic [2:0]        r_left;
  logic [1:0]        r_dd;
  logic              r_sym_valid;
  logic              r_busy;
  logic              r_ready;
  logic              r_err;

  logic [7:0]        w_upper;
  logic [2:0]        w_len;
  logic [3:0]        w_lcode;
  logic [c_CW-1:0]   w_code;
  logic              w_supported;
  logic              w_is_space;

  // Codes are left-aligned: MSB is the first element, 1 = dah.
  always_comb begin
    w_upper = char_in;
    if (char_in >= 8'h61 && char_in <= 8'h7A) begin
      w_upper = char_in - 8'h20;
    end
    w_len   = 3'd0;
    w_lcode = 4'b0000;
    case (w_upper)
      8'h41: begin w_len = 3'd2; w_lcode = 4'b0100; end // A .-
      8'h42: begin w_len = 3'd4; w_lcode = 4'b1000; end // B -...
      8'h43: begin w_len = 3'd4; w_lcode = 4'b1010; end // C -.-.
      8'h44: begin w_len = 3'd3; w_lcode = 4'b1000; end // D -..
      8'h45: begin w_len = 3'd1; w_lcode = 4'b0000; end // E .
      8'h46: begin w_len = 3'd4; w_lcode = 4'b0010; end // F ..-.
      8'h47: begin w_len = 3'd3; w_lcode = 4'b1100; end // G --.
      8'h48: begin w_len = 3'd4; w_lcode = 4'b0000; end // H ....
      8'h49: begin w_len = 3'd2; w_lcode = 4'b0000; end // I ..
      8'h4A: begin w_len = 3'd4; w_lcode = 4'b0111; end // J .---
      8'h4B: begin w_len = 3'd3; w_lcode = 4'b1010; end // K -.-
      8'h4C: begin w_len = 3'd4; w_lcode = 4'b0100; end // L .-..
      8'h4D: begin w_len = 3'd2; w_lcode = 4'b1100; end // M --
      8'h4E: begin w_len = 3'd2; w_lcode = 4'b1000; end // N -.
      8'h4F: begin w_len = 3'd3; w_lcode = 4'b1110; end // O ---
      8'h50: begin w_len = 3'd4; w_lcode = 4'b0110; end // P .--.
      8'h51: begin w_len = 3'd4; w_lcode = 4'b1101; end // Q --.-
      8'h52: begin w_len = 3'd3; w_lcode = 4'b0100; end // R .-.
      8'h53: begin w_len = 3'd3; w_lcode = 4'b0000; end // S ...
      8'h54: begin w_len = 3'd1; w_lcode = 4'b1000; end // T -
      8'h55: begin w_len = 3'd3; w_lcode = 4'b0010; end // U ..-
      8'h56: begin w_len = 3'd4; w_lcode = 4'b0001; end // V ...-
      8'h57: begin w_len = 3'd3; w_lcode = 4'b0110; end // W .--
      8'h58: begin w_len = 3'd4; w_lcode = 4'b1001; end // X -..-
      8'h59: begin w_len = 3'd4; w_lcode = 4'b1011; end // Y -.--
      8'h5A: begin w_len = 3'd4; w_lcode = 4'b1100; end // Z --..
      default: ;
    endcase
`ifdef MORSE_DIGITS_EN
    w_code = {w_lcode, 1'b0};
    case (w_upper)
      8'h30: begin w_len = 3'd5; w_code = 5'b11111; end
      8'h31: begin w_len = 3'd5; w_code = 5'b01111; end
      8'h32: begin w_len = 3'd5; w_code = 5'b00111; end
      8'h33: begin w_len = 3'd5; w_code = 5'b00011; end
      8'h34: begin w_len = 3'd5; w_code = 5'b00001; end
      8'h35: begin w_len = 3'd5; w_code = 5'b00000; end
      8'h36: begin w_len = 3'd5; w_code = 5'b10000; end
      8'h37: begin w_len = 3'd5; w_code = 5'b11000; end
      8'h38: begin w_len = 3'd5; w_code = 5'b11100; end
      8'h39: begin w_len = 3'd5; w_code = 5'b11110; end
      default: ;
    endcase
`else
    w_code = w_lcode;
`endif
    w_supported = (w_len != 3'd0);
    w_is_space  = (char_in == 8'h20);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_code      <= '0;
      r_left      <= 3'd0;
      r_dd        <= c_GAP;
      r_sym_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_ready     <= 1'b1;
      r_err       <= 1'b0;
    end else begin
      r_sym_valid <= 1'b0;
      r_err       <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (char_valid) begin
            if (w_supported) begin
              r_state     <= S_EMIT;
              r_cnt       <= 8'd0;
              r_code      <= w_code;
              r_left      <= w_len - 3'd1;
              r_dd        <= w_code[c_CW-1] ? c_DAH : c_DIT;
              r_sym_valid <= 1'b1;
              r_busy      <= 1'b1;
              r_ready     <= 1'b0;
            end else if (w_is_space) begin
              r_state <= S_WGAP;
              r_cnt   <= 8'd0;
              r_dd    <= c_GAP;
              r_busy  <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_EMIT: begin
          if (r_cnt == c_SYM_LAST) begin
            r_cnt   <= 8'd0;
            r_dd    <= c_GAP;
            r_state <= (r_left != 3'd0) ? S_EGAP : S_LGAP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_EGAP: begin
          // Shift the next element into the MSB as it starts.
          if (r_cnt == c_SYM_LAST) begin
            r_cnt       <= 8'd0;
            r_state     <= S_EMIT;
            r_code      <= r_code << 1;
            r_left      <= r_left - 3'd1;
            r_dd        <= r_code[c_CW-2] ? c_DAH : c_DIT;
            r_sym_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_LGAP: begin
          if (r_cnt == c_GAP_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_WGAP: begin
          if (r_cnt == c_WORD_LAST) begin
            r_cnt   <= 8'd0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 8'd0;
          r_dd    <= c_GAP;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign char_ready = r_ready;
  assign ditDah_out = r_dd;
  assign sym_valid  = r_sym_valid;
  assign busy       = r_busy;
  assign err_char   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_morse_encoder.sv
`default_nettype none
// Testbench for morse_encoder: directed scenarios plus random characters
// checked against a table-driven per-cycle reference model.
module tb_morse_encoder;

  localparam int SYM  = 2;
  localparam int GAP  = 3;
  localparam int WORD = 7;

  logic       clk;
  logic       rst;
  logic [7:0] char_in;
  logic       char_valid;
  logic       char_ready;
  logic [0:1] ditDah_out;
  logic       sym_valid;
  logic       busy;
  logic       err_char;

  int total = 0;
  int bad   = 0;

  // Per-cycle observation: {ditDah[2], sym_valid, busy, char_ready, err_char}
  logic [5:0] exp_q[$];
  logic [5:0] obs_q[$];

  localparam logic [5:0] IDLE_V = 6'b01_0_0_1_0;

  morse_encoder #(
    .SYM_CYCLES (SYM),
    .GAP_CYCLES (GAP),
    .WORD_CYCLES(WORD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .char_in   (char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .ditDah_out(ditDah_out),
    .sym_valid (sym_valid),
    .busy      (busy),
    .err_char  (err_char)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] sample();
    return {ditDah_out, sym_valid, busy, char_ready, err_char};
  endfunction

  function automatic string morse_of(input logic [7:0] c);
    logic [7:0] u;
    u = c;
    if (u >= "a" && u <= "z") u = u - 8'd32;
    case (u)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";
      "D": return "-..";   "E": return ".";     "F": return "..-.";
      "G": return "--.";   "H": return "....";  "I": return "..";
      "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";
      "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
      "S": return "...";   "T": return "-";     "U": return "..-";
      "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
`ifdef MORSE_DIGITS_EN
      "0": return "-----"; "1": return ".----"; "2": return "..---";
      "3": return "...--"; "4": return "....-"; "5": return ".....";
      "6": return "-...."; "7": return "--..."; "8": return "---..";
      "9": return "----.";
`endif
      default: return "";
    endcase
  endfunction

  // Expected outputs from the cycle after the accepting edge through the
  // first IDLE cycle that follows.
  function automatic void model(input logic [7:0] c);
    string      m;
    logic [1:0] s;
    exp_q.delete();
    if (c == 8'h20) begin
      for (int k = 0; k < WORD; k++) exp_q.push_back(6'b01_0_1_0_0);
    end else begin
      m = morse_of(c);
      if (m.len() == 0) begin
        exp_q.push_back(6'b01_0_0_1_1);
      end else begin
        for (int e = 0; e < m.len(); e++) begin
          s = (m[e] == "-") ? 2'b11 : 2'b00;
          for (int k = 0; k < SYM; k++) exp_q.push_back({s, (k == 0), 3'b100});
          if (e < m.len() - 1)
            for (int k = 0; k < SYM; k++) exp_q.push_back(6'b01_0_1_0_0);
        end
        for (int k = 0; k < GAP; k++) exp_q.push_back(6'b01_0_1_0_0);
      end
    end
    exp_q.push_back(IDLE_V);
  endfunction

  // Present a character for one accepting edge and record n cycles.
  task automatic send_capture(input logic [7:0] c, input int n);
    char_in    = c;
    char_valid = 1'b1;
    @(posedge clk); #1;
    char_valid = 1'b0;
    obs_q.delete();
    obs_q.push_back(sample());
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      obs_q.push_back(sample());
    end
  endtask

  task automatic test_reset();
    total++;
    if (sample() !== IDLE_V) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", sample(), IDLE_V);
    end
  endtask

  task automatic test_letter_e();
    int nb, nsv;
    model("E");
    send_capture("E", exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL letter_E cyc%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
    nb = 0; nsv = 0;
    foreach (obs_q[i]) begin
      if (obs_q[i][2]) nb++;
      if (obs_q[i][3]) nsv++;
    end
    total++;
    if (nb !== 5) begin bad++; $display("FAIL E_busy_cycles got=%0d exp=5", nb); end
    total++;
    if (nsv !== 1) begin bad++; $display("FAIL E_sym_pulses got=%0d exp=1", nsv); end
  endtask

  task automatic test_lowercase();
    int nsv;
    model("a");
    send_capture("a", exp_q.size());
    nsv = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL lower_a cyc%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i][3]) nsv++;
    end
    total++;
    if (nsv !== 2) begin bad++; $display("FAIL a_sym_pulses got=%0d exp=2", nsv); end
    model("A");
    send_capture("A", exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL upper_A cyc%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_space_then_t();
    int nb, nsv;
    model(8'h20);
    send_capture(8'h20, exp_q.size());
    nb = 0; nsv = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL space cyc%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
      if (obs_q[i][2]) nb++;
      if (obs_q[i][3]) nsv++;
    end
    total++;
    if (nb !== 7 || nsv !== 0) begin
      bad++;
      $display("FAIL space_busy_sv got=%0d/%0d exp=7/0", nb, nsv);
    end
    model("T");
    send_capture("T", exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL letter_T cyc%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_unsupported();
    logic [7:0] chars[2];
    chars[0] = "#";
    chars[1] = "5";
    foreach (chars[j]) begin
      model(chars[j]);
      send_capture(chars[j], exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL char_%h cyc%0d got=%b exp=%b", chars[j], i, obs_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_first[$];
    int         n_first;
    model("Q");
    exp_first = exp_q;
    n_first   = exp_first.size();
    model("Z");
    exp_q = {exp_first, exp_q};
    char_in    = "Q";
    char_valid = 1'b1;
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk); #1;
      if (i == 0) char_in = "Z";
      obs_q.push_back(sample());
      if (i == n_first) char_valid = 1'b0;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL hold_QZ cyc%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    model("Q");
    send_capture("Q", 2 * SYM + 1);
    total++;
    if (obs_q[2 * SYM] !== exp_q[2 * SYM]) begin
      bad++;
      $display("FAIL Q_second_elem got=%b exp=%b", obs_q[2 * SYM], exp_q[2 * SYM]);
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if (sample() !== IDLE_V) begin
      bad++;
      $display("FAIL async_reset got=%b exp=%b", sample(), IDLE_V);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      total++;
      if (sample() !== IDLE_V) begin
        bad++;
        $display("FAIL reset_hold cyc%0d got=%b exp=%b", i, sample(), IDLE_V);
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    model("E");
    send_capture("E", exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (obs_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL post_reset_E cyc%0d got=%b exp=%b", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] c;
    logic [7:0] punct[4];
    punct[0] = "#"; punct[1] = "!"; punct[2] = "@"; punct[3] = ".";
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: c = 8'h41 + 8'($urandom_range(0, 25));
        5, 6:          c = 8'h61 + 8'($urandom_range(0, 25));
        7:             c = 8'h20;
        8:             c = 8'h30 + 8'($urandom_range(0, 9));
        default:       c = punct[$urandom_range(0, 3)];
      endcase
      model(c);
      send_capture(c, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (obs_q[i] !== exp_q[i]) begin
          bad++;
          $display("FAIL random_%0d_char_%h cyc%0d got=%b exp=%b", n, c, i, obs_q[i], exp_q[i]);
        end
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst        = 1'b1;
    char_valid = 1'b0;
    char_in    = 8'h00;
    #12;
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_letter_e();
    test_lowercase();
    test_space_then_t();
    test_unsupported();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
